alu_issue: RTL

Decode-and-issue stage directly upstream of the combinational `alu`. It accepts RV32I ALU instructions over a valid/ready handshake and decodes them to the `alu` function codes. It reads operands from an internal 32x32 register file, with forwarding from the in-flight op, and drives registered `srca`/`srcb`/`alufunc` into `alu`. It captures `alu`'s result into a writeback register and writes it back to the register file, giving a 2-stage issue/execute pipeline with a stall input and a retire counter.

---
 rtl/alu_issue.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : RV32I ALU-op decode/issue stage with 32x32 register file,
//            EX-slot forwarding and writeback into an external alu.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            stall,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [4:0]      alufunc,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic [31:0]     retired
);

  localparam logic [6:0] c_OPC_REG = 7'b0110011;
  localparam logic [6:0] c_OPC_IMM = 7'b0010011;
  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  localparam logic [2:0] c_F3_ADD = 3'b000;
  localparam logic [2:0] c_F3_SLT = 3'b010;
  localparam logic [2:0] c_F3_OR  = 3'b110;
  localparam logic [2:0] c_F3_AND = 3'b111;

  localparam logic [4:0] c_FN_NOP = 5'd0;
  localparam logic [4:0] c_FN_ADD = 5'd1;
  localparam logic [4:0] c_FN_SUB = 5'd2;
  localparam logic [4:0] c_FN_AND = 5'd3;
  localparam logic [4:0] c_FN_OR  = 5'd4;
  localparam logic [4:0] c_FN_SLT = 5'd5;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_f7;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_f3     = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_f7     = in_instr[31:25];

  logic [4:0]      w_func;
  logic            w_legal;
  logic            w_use_imm;
  logic [XLEN-1:0] w_imm;

  assign w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  always_comb begin
    w_func    = c_FN_NOP;
    w_legal   = 1'b0;
    w_use_imm = 1'b0;
    case (w_opcode)
      c_OPC_REG: begin
        if (w_f7 == c_F7_BASE) begin
          w_legal = 1'b1;
          case (w_f3)
            c_F3_ADD: w_func = c_FN_ADD;
            c_F3_AND: w_func = c_FN_AND;
            c_F3_OR:  w_func = c_FN_OR;
            c_F3_SLT: w_func = c_FN_SLT;
            default:  w_legal = 1'b0;
          endcase
        end else if ((w_f7 == c_F7_ALT) && (w_f3 == c_F3_ADD)) begin
          w_legal = 1'b1;
          w_func  = c_FN_SUB;
        end
      end
      c_OPC_IMM: begin
        w_legal   = 1'b1;
        w_use_imm = 1'b1;
        case (w_f3)
          c_F3_ADD: w_func = c_FN_ADD;
          c_F3_AND: w_func = c_FN_AND;
          c_F3_OR:  w_func = c_FN_OR;
          c_F3_SLT: w_func = c_FN_SLT;
          default:  w_legal = 1'b0;
        endcase
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Register file and EX slot state
  logic [XLEN-1:0] r_rf [32];
  logic [XLEN-1:0] r_srca;
  logic [XLEN-1:0] r_srcb;
  logic [4:0]      r_alufunc;
  logic [4:0]      r_ex_rd;
  logic            r_ex_valid;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;
  logic [31:0]     r_retired;

  // Operand read with forwarding from the op currently at the alu; x0 is
  // never written, so the register file read needs no special case.
  logic            w_fwd_a;
  logic            w_fwd_b;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_srcb_dec;
  logic            w_accept;
  logic            w_retire;

  assign w_fwd_a    = r_ex_valid && (r_ex_rd != 5'd0) && (r_ex_rd == w_rs1);
  assign w_fwd_b    = r_ex_valid && (r_ex_rd != 5'd0) && (r_ex_rd == w_rs2);
  assign w_opa      = w_fwd_a ? alu_result : r_rf[w_rs1];
  assign w_opb      = w_fwd_b ? alu_result : r_rf[w_rs2];
  assign w_srcb_dec = w_use_imm ? w_imm : w_opb;

  assign in_ready = reset && !stall;
  assign w_accept = in_valid && in_ready;
  assign w_retire = !stall && r_ex_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_retire && (r_ex_rd != 5'd0)) begin
      r_rf[r_ex_rd] <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_srca     <= '0;
      r_srcb     <= '0;
      r_alufunc  <= c_FN_NOP;
      r_ex_rd    <= 5'd0;
      r_ex_valid <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
      r_retired  <= 32'd0;
    end else if (stall) begin
      // Everything holds; only a pending illegal pulse is dropped.
      r_illegal <= 1'b0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_result;
        r_retired <= r_retired + 32'd1;
      end

      r_illegal <= w_accept && !w_legal;

      if (w_accept && w_legal) begin
        r_srca     <= w_opa;
        r_srcb     <= w_srcb_dec;
        r_alufunc  <= w_func;
        r_ex_rd    <= w_rd;
        r_ex_valid <= 1'b1;
      end else begin
        r_srca     <= '0;
        r_srcb     <= '0;
        r_alufunc  <= c_FN_NOP;
        r_ex_rd    <= 5'd0;
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign srca     = r_srca;
  assign srcb     = r_srcb;
  assign alufunc  = r_alufunc;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign illegal  = r_illegal && !stall;
  assign retired  = r_retired;

endmodule
`default_nettype wire
